wifi_reset_sequencer: RTL and testbench

Avalon-MM slave that owns the WiFi module's active-low reset line and sequences a complete reset: a programmable low pulse on `wifi_rst_n`, then a programmable boot-wait window, then a `done` flag and an optional interrupt. It sits on the HPS/Nios lightweight bus beside the WiFi UART. Software issues one write and waits on `done` instead of toggling a raw output bit and timing delays in firmware.

---
 rtl/wifi_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_wifi_reset_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wifi_reset_sequencer.sv
// wifi_reset_sequencer: Avalon-MM slave that drives the WiFi module's
// active-low reset through a timed pulse and boot-wait window. When the
// window ends it raises done and, if enabled, a level interrupt.
module wifi_reset_sequencer #(
  parameter logic [31:0] PULSE_DEFAULT = 32'd50000,
  parameter logic [31:0] BOOT_DEFAULT  = 32'd25000000,
  parameter int unsigned AUTO_START    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        wifi_rst_n,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_BOOT   = 2'd2;
  localparam logic [1:0] ST_READY  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pulse_len_q, pulse_len_d;
  logic [31:0] boot_len_q, boot_len_d;
  logic        hold_q, hold_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        rst_n_q, rst_n_d;
  logic        irq_q, irq_d;
  logic        armed_q, armed_d;

  logic        wr_en;
  logic        ctrl_wr;
  logic        start;
  logic        clr_done;
  logic        force_assert;
  logic        auto_go;
  logic [31:0] pulse_load;

  assign wr_en      = chipselect & ~write_n;
  assign ctrl_wr    = wr_en && (address == 2'd0);
  assign start      = ctrl_wr & writedata[0];
  assign clr_done   = ctrl_wr & writedata[3];
  assign pulse_load = (pulse_len_q == '0) ? 32'd1 : pulse_len_q;
  // The edge that clears hold still sees the old hold=1, so it reloads the
  // counter and the full pulse is counted from that edge.
  assign force_assert = hold_d | hold_q;
  assign auto_go      = armed_q && (AUTO_START != 0);

  // Register-file updates from bus writes
  always_comb begin
    pulse_len_d = pulse_len_q;
    boot_len_d  = boot_len_q;
    hold_d      = hold_q;
    irq_en_d    = irq_en_q;
    armed_d     = 1'b0;
    if (ctrl_wr) begin
      hold_d   = writedata[1];
      irq_en_d = writedata[2];
    end
    if (wr_en && (address == 2'd1)) pulse_len_d = writedata;
    if (wr_en && (address == 2'd2)) boot_len_d  = writedata;
  end

  // Sequencer next state, down-counter and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_assert || start || auto_go) begin
      state_d = ST_ASSERT;
      cnt_d   = pulse_load;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q <= 32'd1) begin
            state_d = ST_BOOT;
            cnt_d   = boot_len_q;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_BOOT: begin
          if (cnt_q <= 32'd1) state_d = ST_READY;
          else                cnt_d   = cnt_q - 32'd1;
        end
        ST_IDLE:  state_d = ST_IDLE;
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_IDLE;
      endcase
    end

    done_d = done_q;
    if ((state_d == ST_READY) && (state_q != ST_READY)) done_d = 1'b1;
    else if (clr_done || start || force_assert)         done_d = 1'b0;

    busy_d  = (state_d == ST_ASSERT) || (state_d == ST_BOOT);
    rst_n_d = (state_d != ST_ASSERT);
    irq_d   = done_d & irq_en_d;
  end

  // State and register flops; reset holds the WiFi module in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pulse_len_q <= PULSE_DEFAULT;
      boot_len_q  <= BOOT_DEFAULT;
      hold_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rst_n_q     <= 1'b0;
      irq_q       <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_len_q <= pulse_len_d;
      boot_len_q  <= boot_len_d;
      hold_q      <= hold_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rst_n_q     <= rst_n_d;
      irq_q       <= irq_d;
      armed_q     <= armed_d;
    end
  end

  // Zero-latency register read mux
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {29'b0, irq_en_q, hold_q, 1'b0};
      2'd1: readdata = pulse_len_q;
      2'd2: readdata = boot_len_q;
      2'd3: readdata = {28'b0, state_q, done_q, busy_q};
      default: readdata = '0;
    endcase
  end

  assign wifi_rst_n = rst_n_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_wifi_reset_sequencer.sv
// Self-checking bench for wifi_reset_sequencer: directed scenarios followed
// by random bus traffic, all compared each cycle against an elapsed-time
// reference model of the reset sequence.
module tb_wifi_reset_sequencer;

  localparam logic [31:0] P_DEF = 32'd4;
  localparam logic [31:0] B_DEF = 32'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        wifi_rst_n;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  wifi_reset_sequencer #(
    .PULSE_DEFAULT(P_DEF),
    .BOOT_DEFAULT (B_DEF),
    .AUTO_START   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .wifi_rst_n(wifi_rst_n),
    .irq       (irq)
  );

  // Reference model: a sequence is described by the time elapsed since it
  // was (re)started plus the pulse/boot lengths captured for it.
  bit          m_valid = 1'b0;
  bit          m_inrst, m_act, m_armed, m_hold, m_irqen, m_done;
  int unsigned m_t;
  logic [31:0] m_sp, m_sb, m_plen, m_blen;

  function automatic logic [1:0] m_phase();
    logic [31:0] bw;
    bw = (m_sb == 0) ? 32'd1 : m_sb;
    if (!m_act)                return 2'd0;
    if (m_t < m_sp)            return 2'd1;
    if (m_t < m_sp + bw)       return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [1:0] ph;
    logic       busy;
    ph   = m_phase();
    busy = (ph == 2'd1) || (ph == 2'd2);
    case (a)
      2'd0:    return {29'b0, m_irqen, m_hold, 1'b0};
      2'd1:    return m_plen;
      2'd2:    return m_blen;
      default: return {28'b0, ph, m_done, busy};
    endcase
  endfunction

  task automatic model_step(input logic r, input logic cs, input logic wn,
                            input logic [1:0] a, input logic [31:0] d);
    logic we, ctrl, st, clr, nhold, nirq, frc, entered;
    logic [31:0] bw;
    if (r) begin
      m_valid = 1'b1; m_inrst = 1'b1; m_act = 1'b0; m_armed = 1'b1;
      m_hold = 1'b0; m_irqen = 1'b0; m_done = 1'b0; m_t = 0;
      m_sp = 32'd1; m_sb = 32'd1; m_plen = P_DEF; m_blen = B_DEF;
      return;
    end
    m_inrst = 1'b0;
    we    = cs & ~wn;
    ctrl  = we && (a == 2'd0);
    st    = ctrl & d[0];
    clr   = ctrl & d[3];
    nhold = ctrl ? d[1] : m_hold;
    nirq  = ctrl ? d[2] : m_irqen;
    frc   = nhold | m_hold;
    entered = 1'b0;
    if (frc || st || m_armed) begin
      m_act = 1'b1;
      m_t   = 0;
      m_sp  = (m_plen == 0) ? 32'd1 : m_plen;
    end else if (m_act && (m_phase() != 2'd3)) begin
      m_t = m_t + 1;
      if (m_t == m_sp) m_sb = m_blen;
      bw = (m_sb == 0) ? 32'd1 : m_sb;
      if ((m_t > m_sp) || (m_t == m_sp)) entered = (m_t == m_sp + bw);
    end
    if (entered)              m_done = 1'b1;
    else if (clr || st || frc) m_done = 1'b0;
    m_armed = 1'b0;
    m_hold  = nhold;
    m_irqen = nirq;
    if (we && (a == 2'd1)) m_plen = d;
    if (we && (a == 2'd2)) m_blen = d;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // One bus cycle: check outputs settled from the last edge, then drive the
  // next inputs and advance the model on the edge that samples them.
  task automatic bus_cycle(input logic r, input logic cs, input logic wn,
                           input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    if (m_valid) begin
      check_eq("wifi_rst_n", {31'b0, wifi_rst_n},
               {31'b0, ~(m_inrst | (m_phase() == 2'd1))});
      check_eq("irq", {31'b0, irq}, {31'b0, m_done & m_irqen});
      check_eq($sformatf("readdata[a=%0d]", address), readdata, m_read(address));
    end
    reset = r; chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    model_step(r, cs, wn, a, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_cycle(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic idle(input int unsigned n, input logic [1:0] a);
    repeat (n) bus_cycle(1'b0, 1'b1, 1'b1, a, '0);
  endtask

  initial begin
    logic        r, cs, wn;
    logic [1:0]  a;
    logic [31:0] d;
    int unsigned k;

    // Reset, auto-start with 4/6 defaults, reach READY
    repeat (3) bus_cycle(1'b1, 1'b0, 1'b1, 2'd1, '0);
    idle(14, 2'd3);
    // Zero lengths: one cycle each of pulse and boot
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h1);
    idle(4, 2'd3);
    // Restart in the middle of a 10-cycle pulse
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    idle(4, 2'd3);
    wr(2'd0, 32'h1);
    idle(20, 2'd3);
    // Hold for 20 cycles, then release
    wr(2'd0, 32'h2);
    idle(19, 2'd0);
    wr(2'd0, 32'h0);
    idle(14, 2'd3);
    // Interrupt rises with done, then clr_done with irq_en kept
    wr(2'd0, 32'h4);
    wr(2'd0, 32'h5);
    idle(13, 2'd3);
    wr(2'd0, 32'hC);
    idle(3, 2'd0);
    // Length change during BOOT only affects the next sequence
    wr(2'd2, 32'd6);
    wr(2'd0, 32'h1);
    idle(12, 2'd3);
    wr(2'd1, 32'd8);
    idle(8, 2'd3);
    wr(2'd0, 32'h1);
    idle(18, 2'd3);
    wr(2'd3, 32'hFFFF_FFFF);
    idle(2, 2'd3);

    // Random traffic
    for (int unsigned i = 0; i < 4000; i++) begin
      k  = $urandom_range(0, 199);
      r  = (k == 0);
      a  = 2'($urandom_range(0, 3));
      d  = '0;
      if (k < 140) begin
        cs = 1'($urandom_range(0, 1));
        wn = cs ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        cs = 1'b1;
        wn = 1'b0;
        case (a)
          2'd0: begin
            d = $urandom & 32'hF;
            if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
          end
          2'd3:    d = $urandom;
          default: d = 32'($urandom_range(0, 12));
        endcase
      end
      bus_cycle(r, cs, wn, a, d);
    end
    idle(2, 2'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
